// File: rtl/aer_spike_encoder.sv
// aer_spike_encoder
// Stamps each enabled spike vector with a free-running time counter and
// serializes it into AER events (neuron index + timestamp), lowest index
// first. Events are queued in a show-ahead FIFO and delivered over
// valid/ready. Vectors that cannot be taken because the serializer is
// still busy are dropped whole and counted.
module aer_spike_encoder #(
  parameter int NUM_NEURONS = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int TS_WIDTH    = 16,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic [NUM_NEURONS-1:0]          spike_in,
  input  logic                            clear_stats,
  output logic                            aer_valid,
  input  logic                            aer_ready,
  output logic [ADDR_WIDTH-1:0]           aer_addr,
  output logic [TS_WIDTH-1:0]             aer_timestamp,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic [TS_WIDTH-1:0]             time_now,
  output logic [7:0]                      dropped_count,
  output logic                            overflow
);

  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int PCW = $clog2(NUM_NEURONS + 1);
  localparam int EW  = ADDR_WIDTH + TS_WIDTH;

  // Index of the lowest set bit; zero for an empty vector.
  function automatic logic [ADDR_WIDTH-1:0] lowest_index(input logic [NUM_NEURONS-1:0] v);
    logic [ADDR_WIDTH-1:0] idx;
    idx = {ADDR_WIDTH{1'b0}};
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = ADDR_WIDTH'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Number of set bits in a spike vector.
  function automatic logic [PCW-1:0] popcount(input logic [NUM_NEURONS-1:0] v);
    logic [PCW-1:0] cnt;
    cnt = {PCW{1'b0}};
    for (int i = 0; i < NUM_NEURONS; i++) begin
      cnt = cnt + PCW'(v[i]);
    end
    return cnt;
  endfunction

  logic [TS_WIDTH-1:0]    time_q, time_d;
  logic [NUM_NEURONS-1:0] pend_q, pend_d;
  logic [TS_WIDTH-1:0]    pend_ts_q, pend_ts_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [7:0]             dropped_q, dropped_d;
  logic                   overflow_q, overflow_d;
  logic [EW-1:0]          mem_q [FIFO_DEPTH];

  logic                   valid_s;
  logic                   pop_s;
  logic                   push_s;
  logic                   can_push_s;
  logic [NUM_NEURONS-1:0] pend_after_s;
  logic                   spike_any_s;
  logic                   accept_s;
  logic                   drop_s;
  logic [ADDR_WIDTH-1:0]  push_addr_s;
  logic [EW-1:0]          head_s;
  logic [8:0]             drop_sum_s;
  logic [7:0]             drop_base_s;

  assign valid_s = (count_q != {CW{1'b0}});
  assign head_s  = mem_q[rd_ptr_q];

  // Serializer/FIFO handshake, capture decision and all next-state values.
  always_comb begin
    pop_s        = valid_s & aer_ready;
    can_push_s   = (count_q < CW'(FIFO_DEPTH)) | pop_s;
    push_s       = (pend_q != {NUM_NEURONS{1'b0}}) & can_push_s;
    push_addr_s  = lowest_index(pend_q);
    spike_any_s  = (spike_in != {NUM_NEURONS{1'b0}});
    pend_d       = pend_q;
    pend_ts_d    = pend_ts_q;
    time_d       = time_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    dropped_d    = dropped_q;
    overflow_d   = overflow_q;
    drop_base_s  = dropped_q;
    drop_sum_s   = 9'd0;

    // Clearing the lowest set bit of the pending mask on a push.
    if (push_s) begin
      pend_after_s = pend_q & (pend_q - {{(NUM_NEURONS-1){1'b0}}, 1'b1});
      wr_ptr_d     = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      pend_after_s = pend_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase

    // A new vector is taken only if the serializer is free after this edge.
    accept_s = enable & spike_any_s & (pend_after_s == {NUM_NEURONS{1'b0}});
    drop_s   = enable & spike_any_s & ~accept_s;

    if (accept_s) begin
      pend_d    = spike_in;
      pend_ts_d = time_q;
    end else begin
      pend_d    = pend_after_s;
      pend_ts_d = pend_ts_q;
    end

    if (enable) begin
      time_d = time_q + {{(TS_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      time_d = time_q;
    end

    // Clear first, so a drop on the same edge is still recorded.
    if (clear_stats) begin
      drop_base_s = 8'd0;
      overflow_d  = 1'b0;
    end else begin
      drop_base_s = dropped_q;
      overflow_d  = overflow_q;
    end

    if (drop_s) begin
      drop_sum_s = {1'b0, drop_base_s} + 9'(popcount(spike_in));
      overflow_d = 1'b1;
      if (drop_sum_s > 9'd255) begin
        dropped_d = 8'hFF;
      end else begin
        dropped_d = drop_sum_s[7:0];
      end
    end else begin
      dropped_d = drop_base_s;
    end
  end

  // Control state: time counter, pending vector, FIFO pointers and stats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_q     <= {TS_WIDTH{1'b0}};
      pend_q     <= {NUM_NEURONS{1'b0}};
      pend_ts_q  <= {TS_WIDTH{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      dropped_q  <= 8'd0;
      overflow_q <= 1'b0;
    end else begin
      time_q     <= time_d;
      pend_q     <= pend_d;
      pend_ts_q  <= pend_ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      dropped_q  <= dropped_d;
      overflow_q <= overflow_d;
    end
  end

  // Event storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {push_addr_s, pend_ts_q};
    end
  end

  // Head event presentation, zeroed while the FIFO is empty.
  always_comb begin
    if (valid_s) begin
      aer_addr      = head_s[EW-1:TS_WIDTH];
      aer_timestamp = head_s[TS_WIDTH-1:0];
    end else begin
      aer_addr      = {ADDR_WIDTH{1'b0}};
      aer_timestamp = {TS_WIDTH{1'b0}};
    end
  end

  assign aer_valid     = valid_s;
  assign fifo_count    = count_q;
  assign time_now      = time_q;
  assign dropped_count = dropped_q;
  assign overflow      = overflow_q;

endmodule

// File: doc/aer_spike_encoder.md
Name: aer_spike_encoder

Overview:
- Downstream of the spiking neuron array. Samples the per-neuron spike_out vector each enabled cycle and stamps it with a free-running time counter.
- Serializes simultaneous spikes into Address-Event Representation (AER) events (neuron index plus timestamp), lowest index first, and buffers them in a show-ahead FIFO.
- Delivers events over a valid/ready interface to the router or host.
- Counts and flags spikes lost to back-pressure.

Parameters:
- NUM_NEURONS, 8, width of spike input vector (2..32)
- ADDR_WIDTH, 3, event address width; 2**ADDR_WIDTH >= NUM_NEURONS
- TS_WIDTH, 16, timestamp/time counter width
- FIFO_DEPTH, 16, event FIFO entries; power of 2, >= 2

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- enable  input  1  capture and time-count enable
- spike_in  input  NUM_NEURONS  spike vector, bit i = neuron i fired this cycle
- clear_stats  input  1  synchronous clear of dropped_count and overflow
- aer_valid  output  1  event available at FIFO head
- aer_ready  input  1  consumer accepts event
- aer_addr  output  ADDR_WIDTH  neuron index of head event
- aer_timestamp  output  TS_WIDTH  capture time of head event
- fifo_count  output  $clog2(FIFO_DEPTH+1)  entries held
- time_now  output  TS_WIDTH  current time counter
- dropped_count  output  8  spikes lost, saturating
- overflow  output  1  sticky: at least one spike lost

Behaviour:
- Reset: one clock; rst_n asynchronous, active-low.
  - rst_n=0 immediately clears time_now, pending mask, pending_ts, FIFO pointers, fifo_count, dropped_count and overflow; aer_valid=0.
  - FIFO RAM contents are don't-care.
  - Reset mid-burst discards all pending and queued events.
- Time counter: increments by 1 every clock with enable=1; wraps 2**TS_WIDTH-1 -> 0; frozen when enable=0.
- Capture, at each edge with enable=1 and spike_in != 0:
  - Accepted iff the pending mask is empty after this edge's serializer action: either pending==0, or pending has exactly one bit set and that bit is pushed this edge.
  - Accepted: pending <= spike_in; pending_ts <= time_now (pre-increment value).
  - Rejected: whole vector dropped; dropped_count += popcount(spike_in), saturating at 255; overflow <= 1.
  - enable=0: spike_in ignored, no drop accounting.
- Serializer, every edge regardless of enable:
  - If pending != 0 and the FIFO can accept, push {index of lowest set bit, pending_ts} and clear that bit.
  - FIFO can accept when fifo_count < FIFO_DEPTH, or when full and a pop occurs the same edge.
  - If the FIFO is full with no pop, the serializer stalls and pending holds.
  - Exactly one push per edge maximum.
- Latency: spike sampled at edge E0 -> first event pushed at E1 -> aer_valid=1 after E1. An N-spike vector occupies N consecutive push edges when unstalled.
- FIFO:
  - Show-ahead; aer_valid = (fifo_count != 0).
  - Pop when aer_valid && aer_ready at an edge.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - aer_addr and aer_timestamp are forced to 0 whenever aer_valid=0.
  - aer_addr and aer_timestamp are stable while aer_valid=1 and aer_ready=0.
- Stats:
  - clear_stats=1 zeroes dropped_count and overflow.
  - Same edge as a drop: dropped_count = popcount of that drop, overflow=1.
  - Saturation at 255 keeps overflow=1.
- Event ordering: strictly by capture time, then ascending neuron index.

Test Plan:
- Reset, enable=1, spike_in=8'b0000_0001 for one cycle at time_now=5, aer_ready=1 -> after E1 aer_valid=1, aer_addr=0, aer_timestamp=5; fifo_count returns to 0 after pop.
- spike_in=8'b1010_0100 at time_now=10, aer_ready=1 -> three events in consecutive cycles: addr 2, 5, 7, all timestamp 10.
- aer_ready=0; drive 17 single spikes spaced 2 cycles apart -> fifo_count saturates at 16; one pending event held; later spikes dropped with dropped_count incremented and overflow=1. Raise aer_ready -> 17 events out in order, no duplicates.
- spike_in=8'hFF then 8'h03 next cycle -> second vector dropped; dropped_count=2, overflow=1. Pulse clear_stats -> both return to 0.
- TS_WIDTH=4, enable held 16 cycles -> time_now wraps 15->0. enable=0 for 3 cycles -> time_now frozen and spike_in ignored (no drop count).
- Queue 5 events, then assert rst_n=0 asynchronously mid-cycle -> aer_valid, fifo_count, time_now, dropped_count and overflow go to 0 immediately; no events emitted after release.
